// File: rtl/logic_pkg.sv
// Shared types for the bit-serial logic unit: operation codes and control states.
package logic_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Digit counter must hold 0..steps-1 with one spare bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return $clog2(steps) + 1;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// DIGIT-bit combinational logic slice: per-bit gate primitives followed by an op-select mux.
module logic_slice
  import logic_pkg::*;
#(
  parameter int unsigned DIGIT = 1
) (
  input  op_e              op,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic [DIGIT-1:0] y
);

  logic [DIGIT-1:0] and_w;
  logic [DIGIT-1:0] or_w;
  logic [DIGIT-1:0] xor_w;
  logic [DIGIT-1:0] nor_w;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    and u_and (and_w[i], a[i], b[i]);
    or  u_or  (or_w[i],  a[i], b[i]);
    xor u_xor (xor_w[i], a[i], b[i]);
    nor u_nor (nor_w[i], a[i], b[i]);
  end

  // NOTE: assigning a default before the case keeps this purely combinational (no latch).
  always_comb begin
    y = and_w;
    case (op)
      OP_AND: y = and_w;
      OP_OR:  y = or_w;
      OP_XOR: y = xor_w;
      OP_NOR: y = nor_w;
      default: y = and_w;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/NOR unit: consumes DIGIT bits per cycle from captured operands and
// presents the N-bit result with a zero flag over valid/ready handshakes.
module serial_logic_unit
  import logic_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] f,
  output logic         zero
);

  localparam int unsigned STEPS = N / DIGIT;
  localparam int unsigned CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (DIGIT == 0 || (N % DIGIT) != 0) begin : g_bad_digit
    $error("serial_logic_unit: DIGIT (%0d) must divide N (%0d)", DIGIT, N);
  end

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   f_q, f_d;
  logic           zero_q, zero_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [DIGIT-1:0] slice_y;
  logic [N-1:0]     res_next;

  logic_slice #(.DIGIT(DIGIT)) u_slice (
    .op (op_q),
    .a  (a_q[DIGIT-1:0]),
    .b  (b_q[DIGIT-1:0]),
    .y  (slice_y)
  );

  // New digit enters at the MSB end; after STEPS shifts the first digit sits at bit 0.
  assign res_next = (res_q >> DIGIT) | (N'(slice_y) << (N - DIGIT));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    f_d     = f_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          f_d     = res_next;
          zero_d  = (res_next == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      f_q     <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      f_q     <= f_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign f         = f_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed plus randomized bench for serial_logic_unit (DIGIT=1 and DIGIT=4 instances).
module tb_serial_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, zero;
  logic [31:0] f;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [1:0]  op4 = 2'b00;
  logic [31:0] a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, zero4;
  logic [31:0] f4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_logic_unit #(.N(32), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .f(f), .zero(zero)
  );

  serial_logic_unit #(.N(32), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .f(f4), .zero(zero4)
  );

  // Reference: the logic operation on whole words.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the unit idle; returns after the accepting edge (+1).
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic full_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    logic [31:0] exp;
    exp = model(o, x, y);
    check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    start_op(o, x, y);
    check({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'd32);
    check({tag, "_f"}, f, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    release_out();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] prev_f, exp2, na, nb;
    logic [1:0]  no, ro;
    logic [31:0] ra, rb;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_f", f, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    full_op("or1",  2'b01, 32'hF0F00000, 32'h00000F0F);
    check("or1_value", f, 32'hF0F00F0F);
    full_op("and1", 2'b00, 32'hFFFF0000, 32'h00FFFF00);
    check("and1_value", f, 32'h00FF0000);
    full_op("xor1", 2'b10, 32'hFFFF0000, 32'h00FFFF00);
    check("xor1_value", f, 32'hFF00FF00);
    full_op("nor1", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("nor1_zero", 32'(zero), 32'd1);

    // Backpressure in DONE with new operands waiting.
    start_op(2'b10, 32'h12345678, 32'h0F0F0F0F);
    wait_done(n);
    check("bp_latency", 32'(n), 32'd32);
    prev_f = f;
    check("bp_f", prev_f, 32'h12345678 ^ 32'h0F0F0F0F);
    no = 2'b01; na = 32'hA5A50000; nb = 32'h00005A5A;
    in_valid = 1'b1; op = no; a = na; b = nb;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_f%0d", i), f, prev_f);
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_ready%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_only_out_hs_valid", 32'(out_valid), 32'd0);
    check("bp_only_out_hs_ready", 32'(in_ready), 32'd1);
    check("bp_idle_f_hold", f, prev_f);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_next", 32'(in_ready), 32'd0);
    wait_done(n);
    check("bp_new_latency", 32'(n), 32'd32);
    check("bp_new_f", f, model(no, na, nb));
    release_out();

    // Randomized operations with random backpressure.
    for (int t = 0; t < 8; t++) begin
      ro = 2'($urandom); ra = $urandom; rb = $urandom;
      if (t == 0) rb = ra;
      start_op(ro, ra, rb);
      wait_done(n);
      check($sformatf("rnd%0d_latency", t), 32'(n), 32'd32);
      exp2 = model(ro, ra, rb);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      check($sformatf("rnd%0d_f", t), f, exp2);
      check($sformatf("rnd%0d_zero", t), 32'(zero), 32'(exp2 == 32'd0));
      release_out();
    end

    // Reset in the middle of RUN.
    start_op(2'b01, 32'hDEAD0000, 32'h0000BEEF);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("mid_running", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_f", f, 32'd0);
    check("mid_rst_zero", 32'(zero), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    full_op("post_rst", 2'b01, 32'h00000001, 32'h00000002);
    check("post_rst_value", f, 32'h00000003);

    // DIGIT=4 instance: same OR as the first scenario, 8 cycles.
    in_valid4 = 1'b1; op4 = 2'b01; a4 = 32'hF0F00000; b4 = 32'h00000F0F;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = $urandom; b4 = $urandom;
    check("d4_busy", 32'(in_ready4), 32'd0);
    n = 0;
    while (out_valid4 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("d4_latency", 32'(n), 32'd8);
    check("d4_f", f4, 32'hF0F00F0F);
    check("d4_zero", 32'(zero4), 32'd0);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("d4_idle", 32'(in_ready4), 32'd1);

    // DIGIT=4 random operation.
    ro = 2'($urandom); ra = $urandom; rb = $urandom;
    in_valid4 = 1'b1; op4 = ro; a4 = ra; b4 = rb;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (out_valid4 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("d4_rnd_latency", 32'(n), 32'd8);
    check("d4_rnd_f", f4, model(ro, ra, rb));
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
- Multi-cycle bit-serial logic unit: accepts two N-bit operands and an opcode over a valid/ready input handshake.
- Computes AND/OR/XOR/NOR DIGIT bits per cycle through a gate-level slice, then presents the N-bit result and a zero flag over a valid/ready output handshake.
- Sits beside the parallel gate-level logic blocks as the area-reduced sequential alternative for the ALU logic path.

Parameters:
- N, 32, operand/result width.
- DIGIT, 1, bits processed per cycle. Must divide N; a non-dividing value is an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  unit can accept operands.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- a  input  N  operand A.
- b  input  N  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- f  output  N  result.
- zero  output  1  1 when f == 0.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst_n=0: state=IDLE, out_valid=0, f=0, zero=0, internal shift registers and counter cleared, in_ready=1 (decoded from IDLE).
- States: IDLE, RUN, DONE. in_ready=(state==IDLE); out_valid=(state==DONE). Both are decoded from registered state.
- IDLE: on in_valid&&in_ready at an edge, capture a, b, op into shift registers, clear cnt, go to RUN. f and zero hold the previous result until overwritten.
- RUN, each cycle:
  - the slice combines the low DIGIT bits of the A and B shift registers per the captured op;
  - the DIGIT result bits shift into the result register from the MSB end;
  - the A and B registers shift right by DIGIT;
  - cnt increments.
- RUN exit: when cnt reaches N/DIGIT-1, the final digit is written and state goes to DONE on the same edge. f then holds the full result, LSB-aligned. cnt width is $clog2(N/DIGIT)+1.
- Latency: an accept at edge k gives out_valid=1 after edge k+N/DIGIT (32 cycles for the defaults).
- zero: registered; computed from the complete result on the edge entering DONE.
- DONE: f and zero stay stable while out_ready=0 (any length of backpressure). On out_valid&&out_ready go to IDLE. The next accept can occur at the following edge; there is no same-cycle bypass.
- In RUN/DONE: in_valid is ignored (in_ready=0), and changes on a, b, op have no effect.
- Reset mid-operation: abandons the operation immediately. Outputs return to reset values and no partial result is presented.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes.

Decomposition:
- Package logic_pkg: op enum (OP_AND, OP_OR, OP_XOR, OP_NOR) and state enum (IDLE, RUN, DONE).
- Sub-module logic_slice: DIGIT-bit combinational slice built from 1-bit gate primitives and an op-select mux. It is the only combinational datapath; the top level holds the FSM, counter and shift registers.

Test Plan:
- Reset, then OR with a=0xF0F00000, b=0x00000F0F -> in_ready drops for 32 cycles; out_valid after edge k+32; f=0xF0F00F0F; zero=0.
- AND with a=0xFFFF0000, b=0x00FFFF00 -> f=0x00FF0000. XOR with the same operands -> f=0xFF00FF00.
- NOR with a=b=0xFFFFFFFF -> f=0x00000000, zero=1.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> f and out_valid stable, in_ready=0, nothing accepted. After out_ready=1, the new op is accepted on the next edge.
- Assert rst_n=0 at cycle 10 of RUN -> out_valid=0, f=0 immediately; in_ready=1. After release, OR of 0x1,0x2 completes with f=0x3.
- Instance with DIGIT=4 -> the same OR as scenario 1 completes in 8 cycles with f=0xF0F00F0F.
